// File: rtl/monprod_operand_sequencer.sv
// monprod_operand_sequencer
// Collects N-bit words into the A, B and M operands, starts mon_prod, then
// returns the product P one N-bit word per downstream handshake.
// Optional feature macro: MONPROD_SEQ_KEEP_M_EN (M loaded only on the first
// operation after reset; later operations load A and B only).
//
// state | meaning
// ------+-----------------------------------------------------------
// LOAD  | accepting operand words (order A, B, M; little-endian)
// START | one-cycle start pulse to mon_prod
// WAIT  | waiting for mon_prod stop, then capture P
// EMIT  | present the next result word once the downstream is idle
// GAP   | hold-off after a strobe before out_busy is looked at again
module monprod_operand_sequencer #(
    parameter int N       = 32,
    parameter int BITLEN  = 64,
    parameter int WIDX_W  = 1,
    parameter int HOLDOFF = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [N-1:0]      in_word_i,
    input  logic              in_valid_i,
    output logic              mp_start_o,
    output logic [BITLEN-1:0] mp_a_o,
    output logic [BITLEN-1:0] mp_b_o,
    output logic [BITLEN-1:0] mp_m_o,
    input  logic              mp_stop_i,
    input  logic [BITLEN-1:0] mp_p_i,
    output logic [N-1:0]      out_word_o,
    output logic              out_valid_o,
    input  logic              out_busy_i,
    output logic              busy_o,
    output logic              overrun_o
);

    localparam int WORDS = BITLEN / N;
    localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [WIDX_W-1:0] IDX_LAST = WIDX_W'(WORDS - 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLDOFF - 1);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_EMIT  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SEL_A = 2'd0,
        SEL_B = 2'd1,
        SEL_M = 2'd2
    } sel_t;

    state_t            state_q, state_d;
    sel_t              sel_q, sel_d;
    logic [WIDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BITLEN-1:0] a_q, b_q, m_q, res_q;
    logic [N-1:0]      out_word_q;
    logic              overrun_q;
    logic              load_we;
    logic              emit_fire;
    logic [N-1:0]      res_word;
`ifdef MONPROD_SEQ_KEEP_M_EN
    logic              m_loaded_q, m_loaded_d;
`endif

    assign load_we   = (state_q == S_LOAD) && in_valid_i;
    assign emit_fire = (state_q == S_EMIT) && !out_busy_i;
    assign res_word  = res_q[int'(idx_q) * N +: N];

    assign mp_start_o  = (state_q == S_START);
    assign out_valid_o = emit_fire;
    assign out_word_o  = emit_fire ? res_word : out_word_q;
    assign busy_o      = (state_q != S_LOAD);
    assign overrun_o   = overrun_q;
    assign mp_a_o      = a_q;
    assign mp_b_o      = b_q;
    assign mp_m_o      = m_q;

    // Control state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_LOAD;
            sel_q   <= SEL_A;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MONPROD_SEQ_KEEP_M_EN
    // Remembers that M has been loaded once since reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) m_loaded_q <= 1'b0;
        else          m_loaded_q <= m_loaded_d;
    end
`endif

    // Next-state logic: word sequencing, result emission and hold-off timer.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
`ifdef MONPROD_SEQ_KEEP_M_EN
        m_loaded_d = m_loaded_q;
`endif
        case (state_q)
            S_LOAD: begin
                if (in_valid_i) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        case (sel_q)
                            SEL_A: sel_d = SEL_B;
                            SEL_B: begin
`ifdef MONPROD_SEQ_KEEP_M_EN
                                if (m_loaded_q) begin
                                    sel_d   = SEL_A;
                                    state_d = S_START;
                                end else begin
                                    sel_d = SEL_M;
                                end
`else
                                sel_d = SEL_M;
`endif
                            end
                            SEL_M: begin
                                sel_d   = SEL_A;
                                state_d = S_START;
`ifdef MONPROD_SEQ_KEEP_M_EN
                                m_loaded_d = 1'b1;
`endif
                            end
                            default: sel_d = SEL_A;
                        endcase
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (mp_stop_i) begin
                    idx_d   = '0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (!out_busy_i) begin
                    cnt_d   = CNT_LOAD;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    if (idx_q != IDX_LAST) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_EMIT;
                    end else begin
                        idx_d   = '0;
                        sel_d   = SEL_A;
                        state_d = S_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // Operand, result and output-word registers plus sticky overrun flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_q        <= '0;
            b_q        <= '0;
            m_q        <= '0;
            res_q      <= '0;
            out_word_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            if (load_we) begin
                case (sel_q)
                    SEL_A:   a_q[int'(idx_q) * N +: N] <= in_word_i;
                    SEL_B:   b_q[int'(idx_q) * N +: N] <= in_word_i;
                    SEL_M:   m_q[int'(idx_q) * N +: N] <= in_word_i;
                    default: ;
                endcase
            end
            if (in_valid_i && (state_q != S_LOAD)) overrun_q <= 1'b1;
            if ((state_q == S_WAIT) && mp_stop_i) res_q <= mp_p_i;
            if (emit_fire) out_word_q <= res_word;
        end
    end

endmodule
